instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Control-side counterpart to the main decoder: takes decoded instruction fields, encodes them into 32-bit RV32I words and writes them sequentially into instruction memory.
- Used by the self-test and boot path to load programs without a pre-built hex image.
- Supports exactly the opcode set the control unit decodes: load, store, R-type, branch, I-type ALU, JAL, LUI.

Parameters:
- ADDR_WIDTH, 12: byte-address width of the instruction memory write port.
- BASE_ADDR, 0: first byte address written after start_i.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- start_i  input  1  one-cycle pulse; opens a load session at BASE_ADDR; honoured only in IDLE, DONE, ERROR.
- valid_i  input  1  instruction fields valid.
- ready_o  output  1  encoder can accept fields.
- kind_i  input  3  0 LOAD, 1 STORE, 2 REG, 3 BRANCH, 4 IMM, 5 JAL, 6 LUI, 7 illegal.
- funct3_i  input  3  funct3 field.
- funct7_i  input  7  funct7 field (REG; IMM shifts).
- rd_i, rs1_i, rs2_i  input  5 each  register indices.
- imm_i  input  32  immediate, value as the instruction semantics define it (byte offset, or LUI upper value in imm_i[31:12]).
- last_i  input  1  this is the final instruction of the session.
- mem_we_o  output  1  instruction memory write strobe.
- mem_addr_o  output  ADDR_WIDTH  byte write address, word aligned.
- mem_wdata_o  output  32  encoded instruction.
- busy_o  output  1  session in progress (ACCEPT or WRITE).
- done_o  output  1  one-cycle pulse after the last write.
- error_o  output  1  sticky error flag; cleared only by start_i or reset.
- count_o  output  ADDR_WIDTH-1  number of words written this session.

Behaviour:
- Reset (async, rst_n_i low): state IDLE; all outputs 0; address register = BASE_ADDR; count = 0.
- A reset asserted mid-session aborts immediately, and no write strobe appears in that cycle.
- ready_o = 1 only in ACCEPT.
- A field set transfers when valid_i and ready_o are both high on a rising edge; fields are sampled on that edge only.
- FSM transitions:
  - IDLE: on start_i -> ACCEPT; address = BASE_ADDR, count = 0, error_o = 0.
  - ACCEPT: on transfer with kind_i 0-6, register the encoded word and last_i -> WRITE. On transfer with kind_i = 7 -> ERROR, error_o = 1, no write.
  - WRITE: mem_we_o = 1 for exactly one cycle, with mem_addr_o = current address and mem_wdata_o = encoded word. Next edge: address += 4, count += 1. Then:
    - last registered -> DONE.
    - else if the new address wrapped to 0 (memory full) -> ERROR, error_o = 1.
    - else -> ACCEPT.
  - DONE: done_o = 1 for this single cycle -> IDLE (start_i in this cycle -> ACCEPT instead).
  - ERROR: holds until start_i, which clears error_o and enters ACCEPT.
- Latency: one accepted instruction produces mem_we_o on the following cycle; throughput is one instruction per 2 cycles.
- start_i in ACCEPT or WRITE is ignored.
- mem_addr_o and mem_wdata_o hold their last values when mem_we_o = 0.
- Encoding (opcode in [6:0], rd in [11:7], funct3 in [14:12], rs1 in [19:15], rs2 in [24:20]):
  - LOAD 0000011: imm_i[11:0] in [31:20].
  - IMM 0010011: same as LOAD; if funct3 is 001 or 101, [31:25] = funct7_i and [24:20] = imm_i[4:0].
  - REG 0110011: [31:25] = funct7_i.
  - STORE 0100011: imm[11:5] in [31:25], imm[4:0] in [11:7].
  - BRANCH 1100011: imm[12] in [31], imm[10:5] in [30:25], imm[4:1] in [11:8], imm[11] in [7]; imm_i[0] ignored.
  - JAL 1101111: imm[20] in [31], imm[10:1] in [30:21], imm[11] in [20], imm[19:12] in [19:12].
  - LUI 0110111: imm_i[31:12] in [31:12].
  - Fields unused by a format are not encoded.

Test Plan:
- Encode session: start_i, then ADDI x1,x0,5 (kind 4, imm 5), ADD x3,x1,x2 (kind 2), SW x2,8(x1) (kind 1, funct3 010) with last_i -> writes 0x00500093 @0x000, 0x002081B3 @0x004, 0x0020A423 @0x008; done_o one pulse; count_o = 3.
- Immediate packing: BEQ x1,x2,imm -4 -> 0xFE208EE3; JAL x1,imm 8 -> 0x008000EF; LUI x5, imm_i 0x12345000 -> 0x123452B7.
- Handshake: valid_i held high continuously -> ready_o alternates 1/0, one write per 2 cycles; valid_i low in ACCEPT -> no write, state held.
- Illegal kind 7 -> error_o = 1, no mem_we_o, ready_o = 0; later start_i -> error_o = 0, writes restart at BASE_ADDR.
- Overflow with ADDR_WIDTH = 4 (4 words), 5 instructions, last_i only on the 5th -> 4 writes at 0x0-0xC, then error_o = 1; the 5th instruction is never accepted.
- Reset mid-session: rst_n_i low during the WRITE cycle -> mem_we_o drops immediately; all outputs 0, state IDLE; after release no activity until start_i.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Encodes decoded RV32I instruction fields into 32-bit words and writes them
// sequentially into instruction memory, one word per two cycles.
module instr_encoder_loader #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [2:0]            kind_i,
    input  logic [2:0]            funct3_i,
    input  logic [6:0]            funct7_i,
    input  logic [4:0]            rd_i,
    input  logic [4:0]            rs1_i,
    input  logic [4:0]            rs2_i,
    input  logic [31:0]           imm_i,
    input  logic                  last_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [ADDR_WIDTH-2:0] count_o
);

    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned CW = ADDR_WIDTH - 1;
    localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);

    localparam logic [2:0] K_LOAD   = 3'd0;
    localparam logic [2:0] K_STORE  = 3'd1;
    localparam logic [2:0] K_REG    = 3'd2;
    localparam logic [2:0] K_BRANCH = 3'd3;
    localparam logic [2:0] K_IMM    = 3'd4;
    localparam logic [2:0] K_JAL    = 3'd5;
    localparam logic [2:0] K_LUI    = 3'd6;
    localparam logic [2:0] K_ILLEGAL = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     word_q, word_d;
    logic            last_q, last_d;
    logic            error_q, error_d;
    logic [31:0]     enc_c;
    logic            start_ok_c;

    // Instruction word assembly from the incoming fields
    always_comb begin
        enc_c = '0;
        case (kind_i)
            K_LOAD:   enc_c = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'b0000011};
            K_STORE:  enc_c = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], 7'b0100011};
            K_REG:    enc_c = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, 7'b0110011};
            K_BRANCH: enc_c = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                               imm_i[4:1], imm_i[11], 7'b1100011};
            K_IMM: begin
                enc_c = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'b0010011};
                // shifts carry funct7 in the upper immediate bits
                if (funct3_i == 3'b001 || funct3_i == 3'b101) begin
                    enc_c[31:20] = {funct7_i, imm_i[4:0]};
                end
            end
            K_JAL:    enc_c = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                               rd_i, 7'b1101111};
            K_LUI:    enc_c = {imm_i[31:12], rd_i, 7'b0110111};
            default:  enc_c = '0;
        endcase
    end

    assign start_ok_c = start_i &&
        (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        waddr_d = waddr_q;
        count_d = count_q;
        word_d  = word_q;
        last_d  = last_q;
        error_d = error_q;

        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_ACCEPT: begin
                if (valid_i) begin
                    if (kind_i == K_ILLEGAL) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_WRITE;
                        word_d  = enc_c;
                        last_d  = last_i;
                        waddr_d = addr_q;
                    end
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + AW'(4);
                count_d = count_q + CW'(1);
                if (last_q) begin
                    state_d = S_DONE;
                end else if (addr_d == '0) begin
                    state_d = S_ERROR;
                    error_d = 1'b1;
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase

        if (start_ok_c) begin
            state_d = S_ACCEPT;
            addr_d  = BASE;
            count_d = '0;
            error_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            addr_q  <= BASE;
            waddr_q <= '0;
            count_q <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            waddr_q <= waddr_d;
            count_q <= count_d;
            word_q  <= word_d;
            last_q  <= last_d;
            error_q <= error_d;
        end
    end

    assign ready_o     = (state_q == S_ACCEPT);
    assign mem_we_o    = (state_q == S_WRITE);
    assign busy_o      = (state_q == S_ACCEPT) || (state_q == S_WRITE);
    assign done_o      = (state_q == S_DONE);
    assign error_o     = error_q;
    assign count_o     = count_q;
    assign mem_addr_o  = waddr_q;
    assign mem_wdata_o = word_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader on a 4-word memory: directed
// encodings, handshake, illegal kind, overflow, reset abort, random sessions.
module tb_instr_encoder_loader;

    localparam int unsigned AW = 4;

    logic          clk;
    logic          rst_n;
    logic          start_i;
    logic          valid_i;
    logic          ready_o;
    logic [2:0]    kind_i;
    logic [2:0]    funct3_i;
    logic [6:0]    funct7_i;
    logic [4:0]    rd_i, rs1_i, rs2_i;
    logic [31:0]   imm_i;
    logic          last_i;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic          busy_o, done_o, error_o;
    logic [AW-2:0] count_o;

    instr_encoder_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_i), .valid_i(valid_i),
        .ready_o(ready_o), .kind_i(kind_i), .funct3_i(funct3_i),
        .funct7_i(funct7_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .imm_i(imm_i), .last_i(last_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .busy_o(busy_o),
        .done_o(done_o), .error_o(error_o), .count_o(count_o)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t          exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int unsigned   model_addr = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: places each field at the bit positions the ISA defines
    function automatic logic [31:0] ref_enc(input logic [2:0] k, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [31:0] imm);
        logic [31:0] w;
        w = 32'h0;
        case (k)
            3'd0: begin w[6:0] = 7'h03; w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1; w[31:20] = imm[11:0]; end
            3'd1: begin w[6:0] = 7'h23; w[11:7] = imm[4:0]; w[14:12] = f3; w[19:15] = rs1;
                        w[24:20] = rs2; w[31:25] = imm[11:5]; end
            3'd2: begin w[6:0] = 7'h33; w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1;
                        w[24:20] = rs2; w[31:25] = f7; end
            3'd3: begin w[6:0] = 7'h63; w[7] = imm[11]; w[11:8] = imm[4:1]; w[14:12] = f3;
                        w[19:15] = rs1; w[24:20] = rs2; w[30:25] = imm[10:5]; w[31] = imm[12]; end
            3'd4: begin
                w[6:0] = 7'h13; w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1;
                if (f3 == 3'd1 || f3 == 3'd5) begin w[24:20] = imm[4:0]; w[31:25] = f7; end
                else w[31:20] = imm[11:0];
            end
            3'd5: begin w[6:0] = 7'h6F; w[11:7] = rd; w[19:12] = imm[19:12]; w[20] = imm[11];
                        w[30:21] = imm[10:1]; w[31] = imm[20]; end
            3'd6: begin w[6:0] = 7'h37; w[11:7] = rd; w[31:12] = imm[31:12]; end
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && mem_we_o) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%08h with no expected write at %0t",
                         mem_addr_o, mem_wdata_o, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(mem_addr_o), 32'(e.addr));
                chk("write_data", mem_wdata_o, e.data);
            end
        end
    end

    task automatic set_f(input logic [2:0] k, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
        kind_i = k; funct3_i = f3; funct7_i = f7; rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge
    task automatic xfer(input bit lst, input int max_wait, input bit use_word,
                        input logic [31:0] word, output bit acc);
        logic [31:0] w;
        w = use_word ? word : ref_enc(kind_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i, imm_i);
        last_i  = lst;
        valid_i = 1'b1;
        acc     = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            if (ready_o) begin
                @(posedge clk);
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (acc) begin
            if (kind_i != 3'd7) begin
                exp_q.push_back('{addr: AW'(model_addr), data: w});
                model_addr = (model_addr + 4) % (1 << AW);
            end
            @(negedge clk);
            valid_i = 1'b0;
            chk("ready_low_after_xfer", 32'(ready_o), 32'd0);
        end else begin
            valid_i = 1'b0;
        end
    endtask

    task automatic must_xfer(input bit lst, input bit use_word, input logic [31:0] word);
        bit acc;
        xfer(lst, 10, use_word, word, acc);
        chk("xfer_accepted", 32'(acc), 32'd1);
    endtask

    task automatic do_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        model_addr = 0;
        chk("start_ready", 32'(ready_o), 32'd1);
        chk("start_error_clr", 32'(error_o), 32'd0);
        chk("start_count", 32'(count_o), 32'd0);
    endtask

    // Called right after the last transfer returns (in the WRITE cycle)
    task automatic check_done(input int n);
        @(negedge clk);
        chk("done_pulse", 32'(done_o), 32'd1);
        chk("done_count", 32'(count_o), 32'(n));
        chk("done_not_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        chk("done_single", 32'(done_o), 32'd0);
        chk("idle_not_ready", 32'(ready_o), 32'd0);
    endtask

    initial begin
        bit acc;
        rst_n = 1'b0; start_i = 1'b0; valid_i = 1'b0; last_i = 1'b0;
        set_f(3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_we", 32'(mem_we_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_error", 32'(error_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_addr", 32'(mem_addr_o), 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Encode session with a valid gap and an ignored start in ACCEPT
        do_start();
        set_f(3'd4, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        must_xfer(1'b0, 1'b1, 32'h00500093);
        set_f(3'd2, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        must_xfer(1'b0, 1'b1, 32'h002081B3);
        @(negedge clk);
        start_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start_i = 1'b0;
            chk("hold_ready", 32'(ready_o), 32'd1);
            chk("hold_count", 32'(count_o), 32'd2);
        end
        set_f(3'd1, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        must_xfer(1'b1, 1'b1, 32'h0020A423);
        check_done(3);

        // Immediate packing
        do_start();
        set_f(3'd3, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        must_xfer(1'b0, 1'b1, 32'hFE208EE3);
        set_f(3'd5, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
        must_xfer(1'b0, 1'b1, 32'h008000EF);
        set_f(3'd6, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        must_xfer(1'b1, 1'b1, 32'h123452B7);
        check_done(3);

        // Illegal kind, then restart at base
        do_start();
        set_f(3'd4, 3'd1, 7'd0, 5'd2, 5'd2, 5'd0, 32'd3);
        must_xfer(1'b0, 1'b1, 32'h00311113);
        set_f(3'd7, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd1);
        must_xfer(1'b0, 1'b0, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("err_flag", 32'(error_o), 32'd1);
            chk("err_ready", 32'(ready_o), 32'd0);
        end
        do_start();
        set_f(3'd4, 3'd5, 7'h20, 5'd4, 5'd4, 5'd0, 32'd7);
        must_xfer(1'b1, 1'b1, 32'h40725213);
        check_done(1);

        // Overflow: four writes fill memory, fifth never accepted
        do_start();
        for (int i = 0; i < 4; i++) begin
            set_f(3'd0, 3'd2, 7'd0, 5'(i + 1), 5'd2, 5'd0, 32'(4 * i));
            must_xfer(1'b0, 1'b0, 32'd0);
        end
        set_f(3'd2, 3'd0, 7'd0, 5'd9, 5'd1, 5'd1, 32'd0);
        xfer(1'b1, 6, 1'b0, 32'd0, acc);
        chk("ovf_not_accepted", 32'(acc), 32'd0);
        chk("ovf_error", 32'(error_o), 32'd1);
        chk("ovf_count", 32'(count_o), 32'd4);

        // Reset during the write cycle
        do_start();
        set_f(3'd6, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'hABCD_E000);
        must_xfer(1'b0, 1'b0, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_we", 32'(mem_we_o), 32'd0);
        chk("rstmid_busy", 32'(busy_o), 32'd0);
        chk("rstmid_addr", 32'(mem_addr_o), 32'd0);
        chk("rstmid_wdata", mem_wdata_o, 32'd0);
        chk("rstmid_count", 32'(count_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        valid_i = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rstmid_idle_ready", 32'(ready_o), 32'd0);
        end
        valid_i = 1'b0;

        // Random sessions against the reference model
        for (int s = 0; s < 25; s++) begin
            int n;
            n = int'($urandom_range(1, 4));
            do_start();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    start_i = ($urandom_range(0, 1) == 1);
                    @(negedge clk);
                    start_i = 1'b0;
                end
                set_f(3'($urandom_range(0, 6)), 3'($urandom), 7'($urandom), 5'($urandom),
                      5'($urandom), 5'($urandom), $urandom);
                must_xfer(i == n - 1, 1'b0, 32'd0);
            end
            check_done(n);
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
